// File: rtl/ram8_pkg.sv
// ============================================================================
//  Module      : ram8_pkg
//  Description : Shared sizing constants and word type for the 8 x 16 RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram8_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef logic [WORD_W-1:0] word_t;

endpackage : ram8_pkg

`default_nettype wire

// File: rtl/dmux8way.sv
// ============================================================================
//  Module      : dmux8way
//  Description : 1-to-8 demultiplexer; routes i_in onto the selected output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmux8way
    import ram8_pkg::*;
(
    input  logic              i_in,
    input  logic [ADDR_W-1:0] i_sel,
    output logic [DEPTH-1:0]  o_out
);

    always_comb begin
        o_out        = '0;
        o_out[i_sel] = i_in;
    end

endmodule : dmux8way

`default_nettype wire

// File: rtl/mux8way16.sv
// ============================================================================
//  Module      : mux8way16
//  Description : 8-to-1 multiplexer of 16-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux8way16
    import ram8_pkg::*;
(
    input  logic [DEPTH-1:0][WORD_W-1:0] i_in,
    input  logic [ADDR_W-1:0]            i_sel,
    output logic [WORD_W-1:0]            o_out
);

    assign o_out = i_in[i_sel];

endmodule : mux8way16

`default_nettype wire

// File: rtl/register16.sv
// ============================================================================
//  Module      : register16
//  Description : 16-bit register with synchronous active-low clear and load.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register16
    import ram8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in,
    input  logic              load,
    output logic [WORD_W-1:0] out
);

    word_t r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= in;
        end
    end

    assign out = r_q;

endmodule : register16

`default_nettype wire

// File: rtl/ram8.sv
// ============================================================================
//  Module      : ram8
//  Description : 8-word x 16-bit RAM, synchronous write, combinational read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram8
    import ram8_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out
);

    logic [DEPTH-1:0]             w_load;
    logic [DEPTH-1:0][WORD_W-1:0] w_words;

    // Only the address present at the clock edge matters; glitches between
    // edges merely move the one-hot load around without touching state.
    dmux8way u_dmux (
        .i_in  (load),
        .i_sel (address),
        .o_out (w_load)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        register16 u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .in    (in),
            .load  (w_load[gi]),
            .out   (w_words[gi])
        );
    end

    mux8way16 u_mux (
        .i_in  (w_words),
        .i_sel (address),
        .o_out (out)
    );

endmodule : ram8

`default_nettype wire

// File: tb/tb_ram8.sv
// ============================================================================
//  Module      : tb_ram8
//  Description : Scoreboard-based self-checking bench for ram8.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram8;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;

    logic [15:0] model [8];
    logic [15:0] sb_q [$];
    int          n_pass;
    int          n_total;

    ram8 #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Push expectation when the address is driven, pop when out is sampled.
    task automatic rd(input logic [2:0] a, input string tag);
        @(negedge clk);
        address = a;
        sb_q.push_back(model[a]);
        #1;
        check_val(tag, out, sb_q.pop_front());
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        in      = d;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load     = 1'b0;
        model[a] = d;
    endtask

    task automatic reset_edge();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i++) rd(i[2:0], tag);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        load    = 1'b0;
        in      = 16'h0000;
        address = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;

        read_all("reset_sweep");

        for (int k = 0; k < 8; k++) wr(k[2:0], 16'h1234 + 16'h1111 * k[15:0]);
        read_all("pattern_rb");

        // Write edge: old value visible before the edge, new value after.
        @(negedge clk);
        address = 3'd3;
        in      = 16'hBEEF;
        load    = 1'b1;
        sb_q.push_back(model[3]);
        #1;
        check_val("pre_edge_old", out, sb_q.pop_front());
        sb_q.push_back(16'hBEEF);
        @(posedge clk);
        #1;
        model[3] = 16'hBEEF;
        check_val("post_edge_new", out, sb_q.pop_front());
        load = 1'b0;
        in   = 16'hFFFF;
        @(posedge clk);
        #1;
        sb_q.push_back(model[3]);
        check_val("hold_no_load", out, sb_q.pop_front());

        // Reset wins over a simultaneous write.
        @(negedge clk);
        rst_n   = 1'b0;
        load    = 1'b1;
        address = 3'd5;
        in      = 16'hAAAA;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load  = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        read_all("rst_over_load");

        wr(3'd7, 16'hFFFF);
        wr(3'd0, 16'h0001);
        @(negedge clk);
        for (int t = 0; t < 4; t++) begin
            address = (t % 2 == 0) ? 3'd0 : 3'd7;
            sb_q.push_back(model[address]);
            #1;
            check_val("addr_toggle", out, sb_q.pop_front());
        end
        read_all("after_toggle");

        // Address glitches while load is high: only the settled address is written.
        @(negedge clk);
        in      = 16'h1357;
        load    = 1'b1;
        address = 3'd1;
        #1 address = 3'd4;
        #1 address = 3'd6;
        @(posedge clk);
        #1;
        load     = 1'b0;
        model[6] = 16'h1357;
        read_all("glitch_load");

        for (int k = 0; k < 8; k++) wr(k[2:0], 16'hC000 | k[15:0]);
        reset_edge();
        wr(3'd2, 16'h5A5A);
        read_all("mid_seq_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_ram8

`default_nettype wire

// File: doc/ram8.md
RAM8 -- requirements
Module: ram8

Interface
REQ-001 Parameter: WIDTH, 16, word width in bits; fixed at 16 for this block and present for package consistency only.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low; sampled on rising edge of clk.
REQ-004 Port: in  input  16  write data.
REQ-005 Port: load  input  1  write enable; active-high.
REQ-006 Port: address  input  3  word select, 0..7, shared by read and write.
REQ-007 Port: out  output  16  read data, the word currently stored at address.

Function
REQ-008 The block SHALL hold 8 independent 16-bit registers, R[0]..R[7].
REQ-009 Read SHALL be combinational from stored state: out = R[address] at all times, with zero clock latency and no read enable.
REQ-010 Write: on a rising clk edge with rst_n=1 and load=1, R[address] <= in; all other registers SHALL hold.
REQ-011 On a rising edge with load=0 and rst_n=1, all registers SHALL hold.
REQ-012 Write-then-read: after a write edge, out SHALL show the new value in the same cycle while address is unchanged; during the write cycle itself, out SHALL show the old value (no write-through bypass).
REQ-013 Address changes between edges SHALL change out immediately and SHALL NOT change stored state.
REQ-014 Load decoding SHALL assert exactly one per-register load, or none when load=0; glitches on address while load=1 between edges SHALL NOT corrupt state.
REQ-015 Address has no out-of-range values; all 8 codes SHALL be valid for both read and write.
REQ-016 Input bits SHALL be stored unmodified; there is no masking, sign handling or width conversion.

Reset
REQ-017 On a rising edge with rst_n=0, all of R[0]..R[7] SHALL become 16'h0000, so out = 16'h0000 for every address.
REQ-018 Reset SHALL take priority over load; a write issued in the same edge as reset is discarded.
REQ-019 Reset asserted in the middle of a write sequence SHALL clear all words, including words written earlier; writes SHALL resume on the first edge with rst_n=1.
REQ-020 Before the first reset edge, register contents are undefined; the bench SHALL reset first.

Structure
REQ-021 A shared package SHALL hold WORD_W=16, ADDR_W=3 and DEPTH=8, and ram8 SHALL use these constants.
REQ-022 A single sub-module, register16, SHALL be instantiated 8 times, with ports clk, rst_n, in[15:0], load and out[15:0], giving a synchronous active-low clear and hold-unless-load behaviour.
REQ-023 The per-register load SHALL come from the codebase's 8-way demux gate, and the read path SHALL use the codebase's 8-way 16-bit mux gate selected by address.
REQ-024 There SHALL be no other storage and no latches; the output path SHALL be purely combinational.

Verification
REQ-025 Reset then sweep address 0..7 with load=0 -> out = 16'h0000 at every address.
REQ-026 Write R[k] = 16'h1234 + 16'h1111*k for k = 0..7, then read back all 8 -> each word matches and no aliasing occurs.
REQ-027 Set address=3, in=16'hBEEF, load=1 -> out=16'h(old R[3]) before the edge and 16'hBEEF after it; set load=0 with in=16'hFFFF and clock -> R[3] stays 16'hBEEF.
REQ-028 Assert rst_n=0 and load=1 with in=16'hAAAA at address 5 on the same edge -> all words including R[5] read 16'h0000.
REQ-029 Write R[7]=16'hFFFF and R[0]=16'h0001, then toggle address 0<->7 with no clock -> out follows within #1 and stored words are unchanged.
REQ-030 Write all words, assert reset for one edge, then write R[2]=16'h5A5A -> only R[2] is nonzero.
